// File: rtl/mips_mem_responder.sv
// Memory-side responder for the multicycle MIPS core.
// Holds a byte-addressed RAM, fills it from a valid/ready loader stream
// while the core is held in reset, then serves the core's reads and writes.
module mips_mem_responder #(
    parameter int WIDTH    = 8,
    parameter int ADDRBITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                memread,
    input  logic                memwrite,
    input  logic [WIDTH-1:0]    adr,
    input  logic [WIDTH-1:0]    writedata,
    output logic [WIDTH-1:0]    memdata,
    input  logic                load_valid,
    input  logic [WIDTH-1:0]    load_data,
    input  logic                load_last,
    output logic                load_ready,
    output logic                cpu_rst,
    output logic [ADDRBITS-1:0] load_count
);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDRBITS-1:0] r_loadCount;
    logic [WIDTH-1:0]    r_memdata;
    logic [WIDTH-1:0]    r_mem [0:(2**ADDRBITS)-1];

    logic [ADDRBITS-1:0] w_runAddr;
    logic                w_loadXfer;
    logic                w_full;
    logic                w_memWe;
    logic [ADDRBITS-1:0] w_memAddr;
    logic [WIDTH-1:0]    w_memWdata;
    logic                w_unusedAdr;

    // Only the low address bits select a RAM byte; upper bits alias.
    assign w_runAddr   = adr[ADDRBITS-1:0];
    assign w_unusedAdr = ^adr;

    assign w_loadXfer  = (r_state == LOAD) && load_valid;
    assign w_full      = (r_loadCount == {ADDRBITS{1'b1}});

    // Steer the single RAM write port: loader owns it in LOAD, core in RUN.
    always_comb begin
        w_memWe    = 1'b0;
        w_memAddr  = r_loadCount;
        w_memWdata = load_data;
        if (!rst) begin
            if (w_loadXfer) begin
                w_memWe    = 1'b1;
                w_memAddr  = r_loadCount;
                w_memWdata = load_data;
            end else if ((r_state == RUN) && memwrite) begin
                w_memWe    = 1'b1;
                w_memAddr  = w_runAddr;
                w_memWdata = writedata;
            end
        end
    end

    // Load/run state machine and loader write pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= LOAD;
            r_loadCount <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_loadXfer) begin
                        r_loadCount <= r_loadCount + ADDRBITS'(1);
                        if (load_last || w_full) begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

    // Registered read port; nonblocking read gives read-before-write ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_memdata <= '0;
        end else if ((r_state == RUN) && memread) begin
            r_memdata <= r_mem[w_runAddr];
        end
    end

    // RAM storage is deliberately not cleared by reset so a reload keeps old bytes.
    always_ff @(posedge clk) begin
        if (w_memWe) begin
            r_mem[w_memAddr] <= w_memWdata;
        end
    end

    assign memdata    = r_memdata;
    assign load_count = r_loadCount;
    assign cpu_rst    = (r_state == LOAD);
    assign load_ready = (r_state == LOAD);

endmodule
